// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ctrl
// Purpose  : Single-master I2C register access controller. Performs one
//            register write or one register read (with repeated START)
//            to a fixed 7-bit slave address per start request.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'b001_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] mem_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int                c_QW   = $clog2(CLK_DIV);
    localparam logic [c_QW-1:0]   c_QMAX = c_QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_MADDR, S_MADDR_ACK,
        S_WDATA, S_WDATA_ACK, S_RSTART, S_RADDR, S_RADDR_ACK, S_RDATA,
        S_MNACK, S_STOP
    } state_t;

    state_t          r_state;
    logic [c_QW-1:0] r_qcnt;
    logic [1:0]      r_q;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_rdsh;
    logic            r_rw;
    logic [7:0]      r_maddr;
    logic [7:0]      r_wdata;
    logic            r_nack;
    logic            r_busy;
    logic            r_done;
    logic            r_ack_err;
    logic [7:0]      r_rd_data;
    logic            r_scl;
    logic            r_sda_oe;

    logic            w_tick;
    logic            w_scl;
    logic            w_oe;
    state_t          w_ack_state;

    assign w_tick  = r_busy && (r_qcnt == c_QMAX);
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rd_data = r_rd_data;
    assign scl     = r_scl;
    assign sda     = r_sda_oe ? 1'b0 : 1'bz;

    // Bus levels for the current state/quarter; registered next cycle
    always_comb begin
        w_scl = 1'b1;
        w_oe  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_scl = 1'b1;
                w_oe  = 1'b0;
            end
            S_START: begin
                w_scl = (r_q != 2'd3);
                w_oe  = r_q[1];
            end
            S_RSTART: begin
                w_scl = (r_q == 2'd1) || (r_q == 2'd2);
                w_oe  = r_q[1];
            end
            S_STOP: begin
                w_scl = (r_q != 2'd0);
                w_oe  = (r_q != 2'd3);
            end
            S_ADDR, S_MADDR, S_WDATA, S_RADDR: begin
                w_scl = r_q[1];
                w_oe  = ~r_shift[7];
            end
            default: begin
                // ACK slots, RDATA and MNACK: sda released
                w_scl = r_q[1];
                w_oe  = 1'b0;
            end
        endcase
    end

    // ACK slot that follows each byte state
    always_comb begin
        w_ack_state = S_STOP;
        case (r_state)
            S_ADDR:  w_ack_state = S_ADDR_ACK;
            S_MADDR: w_ack_state = S_MADDR_ACK;
            S_WDATA: w_ack_state = S_WDATA_ACK;
            S_RADDR: w_ack_state = S_RADDR_ACK;
            S_RDATA: w_ack_state = S_MNACK;
            default: w_ack_state = S_STOP;
        endcase
    end

    // Transaction FSM, quarter timing, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_q       <= 2'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_rdsh    <= 8'h00;
            r_rw      <= 1'b0;
            r_maddr   <= 8'h00;
            r_wdata   <= 8'h00;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rd_data <= 8'h00;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_scl    <= w_scl;
            r_sda_oe <= w_oe;
            if (!r_busy) begin
                if (start) begin
                    r_rw      <= rw;
                    r_maddr   <= mem_addr;
                    r_wdata   <= wr_data;
                    r_ack_err <= 1'b0;
                    r_nack    <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= S_START;
                    r_q       <= 2'd0;
                    r_qcnt    <= '0;
                end
            end else begin
                r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
                if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    case (r_state)
                        S_START: begin
                            if (r_q == 2'd3) begin
                                r_state  <= S_ADDR;
                                r_bitcnt <= 3'd7;
                                r_shift  <= {SLAVE_ADDR, 1'b0};
                            end
                        end
                        S_ADDR, S_MADDR, S_WDATA, S_RADDR, S_RDATA: begin
                            if (r_q == 2'd2 && r_state == S_RDATA)
                                r_rdsh <= {r_rdsh[6:0], sda};
                            if (r_q == 2'd3) begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                if (r_bitcnt == 3'd0)
                                    r_state <= w_ack_state;
                                else
                                    r_bitcnt <= r_bitcnt - 3'd1;
                            end
                        end
                        S_ADDR_ACK, S_MADDR_ACK, S_WDATA_ACK, S_RADDR_ACK: begin
                            if (r_q == 2'd2 && sda)
                                r_nack <= 1'b1;
                            if (r_q == 2'd3) begin
                                // A NACK abandons the remaining bytes
                                if (r_nack) begin
                                    r_state <= S_STOP;
                                end else begin
                                    r_bitcnt <= 3'd7;
                                    case (r_state)
                                        S_ADDR_ACK: begin
                                            r_state <= S_MADDR;
                                            r_shift <= r_maddr;
                                        end
                                        S_MADDR_ACK: begin
                                            r_state <= r_rw ? S_RSTART : S_WDATA;
                                            r_shift <= r_wdata;
                                        end
                                        S_RADDR_ACK: r_state <= S_RDATA;
                                        default:     r_state <= S_STOP;
                                    endcase
                                end
                            end
                        end
                        S_RSTART: begin
                            if (r_q == 2'd3) begin
                                r_state  <= S_RADDR;
                                r_bitcnt <= 3'd7;
                                r_shift  <= {SLAVE_ADDR, 1'b1};
                            end
                        end
                        S_MNACK: begin
                            if (r_q == 2'd3)
                                r_state <= S_STOP;
                        end
                        S_STOP: begin
                            if (r_q == 2'd3) begin
                                r_state   <= S_IDLE;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_ack_err <= r_nack;
                                if (r_rw && !r_nack)
                                    r_rd_data <= r_rdsh;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_ctrl
// Purpose  : Self-checking bench for i2c_master_ctrl with an I2C slave model
//            and a bus-event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_ctrl;

    localparam int c_EV_START = 256;
    localparam int c_EV_STOP  = 257;
    localparam int c_EV_MACK  = 258;
    localparam int c_EV_MNACK = 259;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] mem_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda;

    logic       sl_low = 1'b0;
    assign sda = sl_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(4), .SLAVE_ADDR(7'b001_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .mem_addr (mem_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda      (sda)
    );

    int total = 0;
    int bad   = 0;
    int expq[$];
    int obsq[$];

    // Slave model configuration
    logic       cfg_noresp  = 1'b0;
    logic       cfg_regnack = 1'b0;
    logic [7:0] tx_byte     = 8'h5C;

    // Slave model state
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       scl_n, sda_n;
    int         bitn = 0;
    logic [7:0] sh = 8'h00, txb = 8'h00;
    logic       tx = 1'b0, first = 1'b0, acking = 1'b0, acked = 1'b0, rd_req = 1'b0;

    // Slave: decode START/STOP/bits on the bus, ACK bytes, return read data
    always @(negedge clk) begin
        scl_n = scl;
        sda_n = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (scl_p && scl_n && sda_p && !sda_n) begin
            obsq.push_back(c_EV_START);
            bitn = 0; first = 1'b1; tx = 1'b0; acking = 1'b0; sl_low = 1'b0;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
            obsq.push_back(c_EV_STOP);
            bitn = 0; first = 1'b0; tx = 1'b0; acking = 1'b0; sl_low = 1'b0;
        end else if (!scl_p && scl_n) begin
            if (bitn < 8) begin
                sh = {sh[6:0], sda_n};
                bitn++;
                if (bitn == 8 && !tx) obsq.push_back(int'(sh));
            end else if (tx) begin
                obsq.push_back(sda_n ? c_EV_MNACK : c_EV_MACK);
            end
        end else if (scl_p && !scl_n) begin
            if (bitn == 8 && !acking) begin
                acking = 1'b1;
                if (!tx) begin
                    if (first) acked = !cfg_noresp && (sh[7:1] == 7'b001_0000);
                    else       acked = !cfg_noresp && !(cfg_regnack && sh == 8'h20);
                    rd_req = first && sh[0];
                    sl_low = acked;
                end else begin
                    sl_low = 1'b0;
                end
            end else if (acking) begin
                acking = 1'b0;
                bitn   = 0;
                tx     = !tx && acked && rd_req;
                rd_req = 1'b0;
                first  = 1'b0;
                txb    = tx_byte;
                sl_low = tx && !txb[7];
            end else if (tx && bitn < 8) begin
                sl_low = !txb[7 - bitn];
            end
        end
        scl_p = scl_n;
        sda_p = sda_n;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        int e, o;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = (obsq.size() > 0) ? obsq.pop_front() : -1;
            chk({tag, "_event"}, o, e);
        end
        chk({tag, "_extra_events"}, obsq.size(), 0);
    endtask

    // Issue one transaction, measure start-to-done latency, check events
    task automatic run(input logic r, input logic [7:0] a, input logic [7:0] d,
                       input int exp_cyc, input logic mid, input string tag);
        int n;
        rw = r; mem_addr = a; wr_data = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_ackerr_cleared"}, int'(ack_err), 0);
        n = 0;
        while (!done && n < 3000) begin
            if (mid && n == 100) begin
                start = 1'b1; rw = ~r; mem_addr = 8'hFF; wr_data = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, exp_cyc);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        check_events(tag);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", int'(scl), 1);
        chk("rst_sda", int'(sda), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ackerr", int'(ack_err), 0);
        chk("rst_rddata", int'(rd_data), 8'h00);

        // Reset wins over a simultaneous start
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_prio_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Register write
        expq = '{c_EV_START, 8'h20, 8'h03, 8'hA5, c_EV_STOP};
        run(1'b0, 8'h03, 8'hA5, 464, 1'b0, "wr");
        chk("wr_ackerr", int'(ack_err), 0);

        // Register read
        tx_byte = 8'h5C;
        expq = '{c_EV_START, 8'h20, 8'h02, c_EV_START, 8'h21, c_EV_MNACK, c_EV_STOP};
        run(1'b1, 8'h02, 8'h00, 624, 1'b0, "rd");
        chk("rd_data", int'(rd_data), 8'h5C);
        chk("rd_ackerr", int'(ack_err), 0);

        // Address NACK: slave silent
        cfg_noresp = 1'b1;
        expq = '{c_EV_START, 8'h20, c_EV_STOP};
        run(1'b0, 8'h10, 8'h11, 176, 1'b0, "anack");
        chk("anack_ackerr", int'(ack_err), 1);
        chk("anack_busy", int'(busy), 0);
        cfg_noresp = 1'b0;

        // Register-address NACK
        cfg_regnack = 1'b1;
        expq = '{c_EV_START, 8'h20, 8'h20, c_EV_STOP};
        run(1'b0, 8'h20, 8'h77, 320, 1'b0, "rnack");
        chk("rnack_ackerr", int'(ack_err), 1);
        cfg_regnack = 1'b0;

        // Write with an ignored start pulse mid-transfer
        expq = '{c_EV_START, 8'h20, 8'h44, 8'h99, c_EV_STOP};
        run(1'b0, 8'h44, 8'h99, 464, 1'b1, "mid");
        chk("mid_ackerr", int'(ack_err), 0);

        // Reset in the middle of the data byte
        rw = 1'b0; mem_addr = 8'h07; wr_data = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (320) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_scl", int'(scl), 1);
        chk("mrst_sda", int'(sda), 1);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_rddata", int'(rd_data), 8'h00);
        repeat (8) @(posedge clk);
        #1;
        chk("mrst_idle_busy", int'(busy), 0);
        obsq.delete();

        // Normal write after the reset
        expq = '{c_EV_START, 8'h20, 8'h05, 8'h3C, c_EV_STOP};
        run(1'b0, 8'h05, 8'h3C, 464, 1'b0, "post");
        chk("post_ackerr", int'(ack_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
